// File: rtl/if_id_skid_register.sv
// IF/ID boundary register with a 2-entry skid buffer (main + skid).
// Presents the oldest fetched instruction to decode, split into opcode and
// the [31:7] field, stamped with the free-running cycle count at accept time.
module if_id_skid_register #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Stall,
  input  logic        Flush,
  output logic        out_valid,
  output logic [31:0] IF_pc_out,
  output logic [6:0]  IF_opcode,
  output logic [24:0] IF_instruction_out,
  output logic [63:0] IF_cycle
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] cyc;
  } entry_t;

  entry_t      main_q, skid_q, new_e;
  logic        skid_valid;
  logic [63:0] cycle_cnt;
  logic        accept, consume;

  // in_ready depends only on state, so Stall never reaches it combinationally
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & ~Stall;
  assign new_e    = '{pc: pc_in, instr: instr_in, cyc: cycle_cnt};

  // Free-running cycle counter; flush does not disturb it
  always_ff @(posedge clk) begin
    if (!rst) cycle_cnt <= '0;
    else      cycle_cnt <= cycle_cnt + 64'd1;
  end

  // Buffer occupancy and entry movement; flush beats stall and accept
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '{pc: RESET_PC, instr: NOP_INSTR, cyc: 64'd0};
      skid_q     <= '{pc: RESET_PC, instr: NOP_INSTR, cyc: 64'd0};
    end else if (Flush) begin
      // main_q.pc is kept so the empty output still shows the last PC
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume && skid_valid) begin
      main_q <= skid_q;
      if (accept) skid_q <= new_e;
      else        skid_valid <= 1'b0;
    end else if (consume) begin
      if (accept) main_q <= new_e;
      else        out_valid <= 1'b0;
    end else if (!out_valid && accept) begin
      main_q    <= new_e;
      out_valid <= 1'b1;
    end else if (out_valid && accept) begin
      skid_q     <= new_e;
      skid_valid <= 1'b1;
    end
  end

  // Empty main presents a NOP bubble with a zero stamp
  always_comb begin
    IF_pc_out          = main_q.pc;
    IF_opcode          = NOP_INSTR[6:0];
    IF_instruction_out = NOP_INSTR[31:7];
    IF_cycle           = 64'd0;
    if (out_valid) begin
      IF_opcode          = main_q.instr[6:0];
      IF_instruction_out = main_q.instr[31:7];
      IF_cycle           = main_q.cyc;
    end
  end

endmodule

// File: tb/tb_if_id_skid_register.sv
// Directed bench for if_id_skid_register: streaming, skid fill/drain,
// flush priority, field split and mid-operation reset.
module tb_if_id_skid_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0;
  logic        in_valid = 1'b0, Stall = 1'b0, Flush = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] IF_pc_out;
  logic [6:0]  IF_opcode;
  logic [24:0] IF_instruction_out;
  logic [63:0] IF_cycle;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD = 32'h0020_81B3;
  localparam logic [31:0] I_SW  = 32'hFE50_A023;

  if_id_skid_register dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
    .in_valid(in_valid), .in_ready(in_ready), .Stall(Stall), .Flush(Flush),
    .out_valid(out_valid), .IF_pc_out(IF_pc_out), .IF_opcode(IF_opcode),
    .IF_instruction_out(IF_instruction_out), .IF_cycle(IF_cycle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle before sampling
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic st, input logic fl);
    in_valid = v; pc_in = pc; instr_in = ins; Stall = st; Flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag, input logic [31:0] pc);
    chk({tag, ".ov"},  out_valid, 0);
    chk({tag, ".op"},  IF_opcode, 7'h13);
    chk({tag, ".ins"}, IF_instruction_out, 25'h0);
    chk({tag, ".cyc"}, IF_cycle, 0);
    chk({tag, ".pc"},  IF_pc_out, pc);
  endtask

  task automatic chk_main(input string tag, input logic [31:0] pc, input logic [63:0] cyc);
    chk({tag, ".ov"},  out_valid, 1);
    chk({tag, ".pc"},  IF_pc_out, pc);
    chk({tag, ".cyc"}, IF_cycle, cyc);
  endtask

  initial begin
    // reset
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(1, 32'h99, I_ADD, 0, 0);
    chk_empty("rst", 32'h0);
    chk("rst.rdy", in_ready, 1);
    rst = 1'b1;

    // streaming: stamps 0,1,2
    step(1, 32'h0, I_ADD, 0, 0);
    chk_main("s0", 32'h0, 0);
    chk("s0.op", IF_opcode, 7'h33);
    step(1, 32'h4, I_ADD, 0, 0);
    chk_main("s1", 32'h4, 1);
    step(1, 32'h8, I_ADD, 0, 0);
    chk_main("s2", 32'h8, 2);
    step(0, 32'h0, 0, 0, 0);
    chk_empty("drain", 32'h8);

    // skid fill and in-order drain
    step(1, 32'h10, I_ADD, 0, 0);
    chk_main("k0", 32'h10, 4);
    step(1, 32'h14, I_ADD, 1, 0);
    chk_main("k1", 32'h10, 4);
    chk("k1.rdy", in_ready, 0);
    step(1, 32'h18, I_ADD, 1, 0);
    chk_main("k2", 32'h10, 4);
    chk("k2.rdy", in_ready, 0);
    step(1, 32'h18, I_ADD, 0, 0);
    chk_main("k3", 32'h14, 5);
    chk("k3.rdy", in_ready, 1);
    step(1, 32'h18, I_ADD, 0, 0);
    chk_main("k4", 32'h18, 8);

    // flush with both entries full and in_valid high
    step(1, 32'h1C, I_ADD, 1, 0);
    chk("f0.rdy", in_ready, 0);
    step(1, 32'h20, I_ADD, 0, 1);
    chk_empty("f1", 32'h18);
    chk("f1.rdy", in_ready, 1);
    step(0, 32'h0, 0, 0, 0);
    chk_empty("f2", 32'h18);
    // flush drops a same-cycle accept while empty
    step(1, 32'h24, I_ADD, 0, 1);
    chk_empty("f3", 32'h18);

    // flush together with stall
    step(1, 32'h30, I_ADD, 0, 0);
    chk_main("fs0", 32'h30, 13);
    step(1, 32'h34, I_ADD, 1, 0);
    chk("fs1.rdy", in_ready, 0);
    step(0, 32'h0, 0, 1, 1);
    chk_empty("fs2", 32'h30);
    chk("fs2.rdy", in_ready, 1);

    // field split
    step(1, 32'h40, I_SW, 0, 0);
    chk_main("dec", 32'h40, 16);
    chk("dec.op",  IF_opcode, 7'h23);
    chk("dec.ins", IF_instruction_out, 25'h1FCA140);

    // reset with skid occupied and stall held
    step(1, 32'h44, I_ADD, 1, 0);
    chk("r0.rdy", in_ready, 0);
    rst = 1'b0;
    step(1, 32'h48, I_ADD, 1, 0);
    chk_empty("r1", 32'h0);
    chk("r1.rdy", in_ready, 1);
    rst = 1'b1;
    step(1, 32'h50, I_ADD, 0, 0);
    chk_main("r2", 32'h50, 0);
    step(1, 32'h54, I_ADD, 0, 0);
    chk_main("r3", 32'h54, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
